// File: rtl/version_store.sv
// Multi-version register file: versioned writes via valid/ready, a sequential
// GC sweep that retires stale versions, and packed tag/data buses for the router.
module version_store #(
  parameter int DATA_WIDTH    = 32,
  parameter int VERSION_WIDTH = 4,
  parameter int VERSION_NUM   = 4
) (
  input  logic                                clk,
  input  logic                                rstN,
  input  logic                                wrValid,
  output logic                                wrReady,
  input  logic [VERSION_WIDTH-1:0]            wrVersion,
  input  logic [DATA_WIDTH-1:0]               wrData,
  output logic                                wrDropped,
  input  logic                                gcStart,
  input  logic [VERSION_WIDTH-1:0]            gcVersion,
  output logic                                gcDone,
  output logic [VERSION_WIDTH*VERSION_NUM-1:0] versions,
  output logic [DATA_WIDTH*VERSION_NUM-1:0]   dataInputs,
  output logic [$clog2(VERSION_NUM):0]        count,
  output logic                                full
);

  localparam int IDX_W = $clog2(VERSION_NUM);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VERSION_NUM - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(VERSION_NUM);

  typedef enum logic [1:0] {ST_IDLE, ST_COMMIT, ST_SCAN, ST_PURGE} state_t;

  state_t                   state_q, state_d;
  logic [VERSION_WIDTH-1:0] tag_q  [VERSION_NUM];
  logic [VERSION_WIDTH-1:0] tag_d  [VERSION_NUM];
  logic [DATA_WIDTH-1:0]    data_q [VERSION_NUM];
  logic [DATA_WIDTH-1:0]    data_d [VERSION_NUM];
  logic [VERSION_NUM-1:0]   valid_q, valid_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     full_q, full_d;
  logic                     drop_q, drop_d;
  logic [VERSION_WIDTH-1:0] lat_ver_q, lat_ver_d;
  logic [DATA_WIDTH-1:0]    lat_data_q, lat_data_d;
  logic [VERSION_WIDTH-1:0] gc_ver_q, gc_ver_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [IDX_W-1:0]         keep_idx_q, keep_idx_d;
  logic                     keep_found_q, keep_found_d;

  logic                     match_found, free_found, min_seen;
  logic [IDX_W-1:0]         match_idx, free_idx, min_idx;
  logic [VERSION_WIDTH-1:0] min_tag;

  // Slot search for COMMIT: existing tag, lowest free slot, smallest valid tag.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    min_seen    = 1'b0;
    min_idx     = '0;
    min_tag     = '0;
    for (int unsigned i = 0; i < VERSION_NUM; i++) begin
      if (valid_q[i] && tag_q[i] == lat_ver_q) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (valid_q[i] && (!min_seen || tag_q[i] < min_tag)) begin
        min_seen = 1'b1;
        min_tag  = tag_q[i];
        min_idx  = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    data_d       = data_q;
    valid_d      = valid_q;
    count_d      = count_q;
    drop_d       = 1'b0;
    lat_ver_d    = lat_ver_q;
    lat_data_d   = lat_data_q;
    gc_ver_d     = gc_ver_q;
    idx_d        = idx_q;
    keep_idx_d   = keep_idx_q;
    keep_found_d = keep_found_q;
    case (state_q)
      ST_IDLE: begin
        if (gcStart) begin
          gc_ver_d     = gcVersion;
          idx_d        = '0;
          keep_idx_d   = '0;
          keep_found_d = 1'b0;
          state_d      = ST_SCAN;
        end else if (wrValid) begin
          lat_ver_d  = wrVersion;
          lat_data_d = wrData;
          state_d    = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (lat_ver_q == '0) begin
          drop_d = 1'b1;
        end else if (match_found) begin
          data_d[match_idx] = lat_data_q;
        end else if (free_found) begin
          tag_d[free_idx]   = lat_ver_q;
          data_d[free_idx]  = lat_data_q;
          valid_d[free_idx] = 1'b1;
          count_d           = count_q + CNT_W'(1);
        end else if (min_seen && lat_ver_q > min_tag) begin
          tag_d[min_idx]  = lat_ver_q;
          data_d[min_idx] = lat_data_q;
        end else begin
          drop_d = 1'b1;
        end
      end
      ST_SCAN: begin
        if (valid_q[idx_q] && tag_q[idx_q] < gc_ver_q &&
            (!keep_found_q || tag_q[idx_q] > tag_q[keep_idx_q])) begin
          keep_found_d = 1'b1;
          keep_idx_d   = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_PURGE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_PURGE: begin
        if (valid_q[idx_q] && tag_q[idx_q] < gc_ver_q &&
            !(keep_found_q && idx_q == keep_idx_q)) begin
          valid_d[idx_q] = 1'b0;
          tag_d[idx_q]   = '0;
          count_d        = count_q - CNT_W'(1);
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    full_d = (count_d == FULL_CNT);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= ST_IDLE;
      for (int unsigned i = 0; i < VERSION_NUM; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      valid_q      <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      drop_q       <= 1'b0;
      lat_ver_q    <= '0;
      lat_data_q   <= '0;
      gc_ver_q     <= '0;
      idx_q        <= '0;
      keep_idx_q   <= '0;
      keep_found_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      full_q       <= full_d;
      drop_q       <= drop_d;
      lat_ver_q    <= lat_ver_d;
      lat_data_q   <= lat_data_d;
      gc_ver_q     <= gc_ver_d;
      idx_q        <= idx_d;
      keep_idx_q   <= keep_idx_d;
      keep_found_q <= keep_found_d;
    end
  end

  always_comb begin
    versions   = '0;
    dataInputs = '0;
    for (int unsigned i = 0; i < VERSION_NUM; i++) begin
      versions[i*VERSION_WIDTH +: VERSION_WIDTH] = tag_q[i];
      dataInputs[i*DATA_WIDTH +: DATA_WIDTH]     = data_q[i];
    end
  end

  assign wrReady   = (state_q == ST_IDLE) && !gcStart;
  assign gcDone    = (state_q == ST_PURGE) && (idx_q == LAST_IDX);
  assign wrDropped = drop_q;
  assign count     = count_q;
  assign full      = full_q;

endmodule
